wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles a granted cycle may wait for slave ack; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  main clock, single clock domain for all logic.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have ports m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  instruction-side master (ICMU) cycle/strobe/write.
REQ-005 SHALL have ports m0_addr_i [31:2], m0_cti_i [2:0], m0_bte_i [1:0], m0_sel_i [3:0], m0_data_i [31:0]  input  ICMU address/burst/select/write data.
REQ-006 SHALL have ports m0_data_o [31:0], m0_ack_o [1]  output  ICMU read data and acknowledge.
REQ-007 SHALL have port set m1_* identical to REQ-004..006 for the data-side master (DCMU).
REQ-008 SHALL have ports s_cyc_o, s_stb_o, s_we_o [1], s_addr_o [31:2], s_cti_o [2:0], s_bte_o [1:0], s_sel_o [3:0], s_data_o [31:0]  output  shared slave bus.
REQ-009 SHALL have ports s_data_i [31:0], s_ack_i [1]  input  slave read data and acknowledge.
REQ-010 SHALL have ports gnt_o [1:0] output one-hot current grant; timeout_o [1] output one-cycle timeout pulse.

Function
REQ-011 SHALL implement states IDLE, GNT0, GNT1, with grant registered (one-cycle arbitration latency from cyc to s_cyc_o).
REQ-012 IDLE: no request -> stay; only mX_cyc_i -> GNTX; both -> per priority policy (REQ-025).
REQ-013 GNTX SHALL hold while mX_cyc_i=1, including between strobes and across bursts (cti 3'b010 through 3'b111), no preemption.
REQ-014 GNTX with mX_cyc_i=0 SHALL return to IDLE; one IDLE cycle between grants (no back-to-back handoff).
REQ-015 In GNTX, all s_*_o SHALL equal mX_*_i combinationally; in IDLE all s_*_o SHALL be 0.
REQ-016 mX_ack_o SHALL equal s_ack_i & mX_stb_i only while GNTX; ungranted master ack=0.
REQ-017 mX_data_o SHALL equal s_data_i while GNTX, else 32'h0.
REQ-018 Wait counter SHALL clear on every s_ack_i or state change and count cycles with s_stb_o=1 & s_ack_i=0.
REQ-019 Counter reaching TIMEOUT_CYCLES SHALL: pulse timeout_o one cycle, force mX_ack_o=1 with mX_data_o=32'h0 that cycle, suppress s_stb_o that cycle, clear counter.
REQ-020 Real s_ack_i in the same cycle as timeout SHALL win: normal ack, no timeout_o.
REQ-021 s_ack_i while IDLE SHALL be ignored (no master ack).
REQ-022 gnt_o SHALL be 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.

Reset
REQ-023 rst SHALL force IDLE, counter 0, round-robin pointer to m1-preferred, all outputs 0 on the following cycle.
REQ-024 rst mid-transfer SHALL drop s_cyc_o/s_stb_o next cycle without ack to the master; outstanding slave ack discarded.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests go to master not granted most recently (pointer updates on each GNT entry); undefined: fixed priority, m1 (data) always wins ties.
REQ-026 Without ARB_ROUND_ROBIN_EN no pointer register SHALL be synthesized.

Structure
REQ-027 State encodings and CTI codes (CLASSIC 3'b000, INCR 3'b010, END 3'b111) SHALL live in the shared wishbone define package.
REQ-028 Timeout counter SHALL be sub-module wb_arb_timer (inputs clr, cnt_en; output expire), width clog2(TIMEOUT_CYCLES+1).

Verification
REQ-029 m0 classic read addr 30'h100, slave ack after 2 cycles data 32'hDEADBEEF -> s_cyc_o one cycle after m0_cyc_i, m0 gets ack with DEADBEEF, m1_ack_o=0 throughout.
REQ-030 m0,m1 raise cyc same cycle, repeated 4 times -> fixed: GNT1 each time; round-robin: GNT1,GNT0,GNT1,GNT0.
REQ-031 m1 4-beat burst (cti 010,010,010,111) while m0 requests at beat 2 -> no preemption, m0 granted two cycles after m1 drops cyc.
REQ-032 TIMEOUT_CYCLES=8, slave never acks -> timeout_o pulse on wait cycle 8, master ack with data 0, counter restarts.
REQ-033 rst asserted mid-burst of m0 -> next cycle IDLE, s_cyc_o=0, gnt_o=00, no m0 ack.
REQ-034 s_ack_i coincident with timeout expiry -> normal ack with slave data, timeout_o=0.

Source files
------------

// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone definitions for the two-master arbiter: FSM state encoding,
// CTI burst codes, the request bundle and the timeout-counter width helper.
package wb_master_arbiter_pkg;

  // The grant states are one-hot, so the state register is also the gnt_o value.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:2] addr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic [31:0] data;
  } wb_req_t;

  // Width needed to hold 0..n. n = 0 still gets one bit so the declaration stays legal.
  function automatic int unsigned timer_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_master_arbiter_timer.sv
// wb_arb_timer: counts consecutive wait cycles and flags expiry on the
// TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 builds no counter.
module wb_arb_timer
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expire
);

  localparam int unsigned W = timer_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
      logic [W-1:0] count_q;

      // Expiry is flagged during the wait cycle itself, so a master is released
      // in the same cycle the limit is reached rather than one cycle later.
      assign expire = cnt_en && (count_q == LAST);

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      always_ff @(posedge clk) begin
        if (rst || clr || expire) count_q <= '0;
        else if (cnt_en)          count_q <= count_q + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction side, m1 = data side) with a
// slave-ack timeout. Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:2] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  arb_state_e state_q, state_d;
  wb_req_t    m0_req, m1_req, s_req;
  logic       tie_to_m1;
  logic       cnt_en, timer_clr, expire;

  assign m0_req = '{m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_cti_i, m0_bte_i, m0_sel_i, m0_data_i};
  assign m1_req = '{m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_cti_i, m1_bte_i, m1_sel_i, m1_data_i};

`ifdef ARB_ROUND_ROBIN_EN
  logic prefer_m1_q;

  // Whoever was granted last loses the next tie.
  always_ff @(posedge clk) begin
    if (rst)                                           prefer_m1_q <= 1'b1;
    else if (state_q == ST_IDLE && state_d == ST_GNT0) prefer_m1_q <= 1'b1;
    else if (state_q == ST_IDLE && state_d == ST_GNT1) prefer_m1_q <= 1'b0;
  end

  assign tie_to_m1 = prefer_m1_q;
`else
  assign tie_to_m1 = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Counting uses the master strobe rather than s_stb_o, because s_stb_o is
  // itself masked by expire.
  assign cnt_en = ((state_q == ST_GNT0 && m0_stb_i) ||
                   (state_q == ST_GNT1 && m1_stb_i)) && !s_ack_i;
  assign timer_clr = s_ack_i || (state_d != state_q);

  wb_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .cnt_en(cnt_en),
    .expire(expire)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    s_req     = '0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (m1_cyc_i && (!m0_cyc_i || tie_to_m1)) state_d = ST_GNT1;
        else if (m0_cyc_i)                        state_d = ST_GNT0;
      end
      ST_GNT0: begin
        if (!m0_cyc_i) state_d = ST_IDLE;
        s_req     = m0_req;
        s_req.stb = m0_stb_i && !expire;
        m0_ack_o  = (s_ack_i && m0_stb_i) || expire;
        m0_data_o = expire ? '0 : s_data_i;
      end
      ST_GNT1: begin
        if (!m1_cyc_i) state_d = ST_IDLE;
        s_req     = m1_req;
        s_req.stb = m1_stb_i && !expire;
        m1_ack_o  = (s_ack_i && m1_stb_i) || expire;
        m1_data_o = expire ? '0 : s_data_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_cyc_o   = s_req.cyc;
  assign s_stb_o   = s_req.stb;
  assign s_we_o    = s_req.we;
  assign s_addr_o  = s_req.addr;
  assign s_cti_o   = s_req.cti;
  assign s_bte_o   = s_req.bte;
  assign s_sel_o   = s_req.sel;
  assign s_data_o  = s_req.data;
  assign gnt_o     = state_q;
  assign timeout_o = expire;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_wb_master_arbiter;
  import wb_master_arbiter_pkg::*;

  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:2] m_addr[2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_wdat[2];
  logic [31:0] m0_rdata, m1_rdata, s_data_o, s_data;
  logic        m0_ack, m1_ack, s_cyc_o, s_stb_o, s_we_o, s_ack, timeout_o;
  logic [31:2] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o, gnt_o;
  logic [3:0]  s_sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), how long the
  // owner has been waiting on the slave, and who wins the next tie.
  int owner = 0;
  int waitc = 0;
  bit pref_m1 = 1'b1;
  bit model_valid = 1'b0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_addr_i(m_addr[0]),
    .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_sel_i(m_sel[0]), .m0_data_i(m_wdat[0]),
    .m0_data_o(m0_rdata), .m0_ack_o(m0_ack),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_addr_i(m_addr[1]),
    .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_sel_i(m_sel[1]), .m1_data_i(m_wdat[1]),
    .m1_data_o(m1_rdata), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
    .s_data_i(s_data), .s_ack_i(s_ack), .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_timeout();
    if (owner == 0) return 1'b0;
    return m_stb[owner-1] && !s_ack && (waitc == TO - 1);
  endfunction

  task automatic check_outputs();
    bit          to;
    int          i;
    logic        e_cyc, e_stb, e_we;
    logic [29:0] e_addr;
    logic [2:0]  e_cti;
    logic [1:0]  e_bte;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    if (!model_valid) return;
    to = model_timeout();
    {e_cyc, e_stb, e_we, e_addr, e_cti, e_bte, e_sel, e_dat} = '0;
    if (owner != 0) begin
      i = owner - 1;
      e_cyc = m_cyc[i]; e_stb = m_stb[i] && !to; e_we = m_we[i]; e_addr = m_addr[i];
      e_cti = m_cti[i]; e_bte = m_bte[i]; e_sel = m_sel[i]; e_dat = m_wdat[i];
    end
    check("gnt",     gnt_o, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
    check("timeout", timeout_o, to);
    check("s_cyc",   s_cyc_o, e_cyc);
    check("s_stb",   s_stb_o, e_stb);
    check("s_we",    s_we_o, e_we);
    check("s_addr",  s_addr_o, e_addr);
    check("s_cti",   s_cti_o, e_cti);
    check("s_bte",   s_bte_o, e_bte);
    check("s_sel",   s_sel_o, e_sel);
    check("s_data",  s_data_o, e_dat);
    check("m0_ack",  m0_ack, (owner == 1) && ((s_ack && m_stb[0]) || to));
    check("m1_ack",  m1_ack, (owner == 2) && ((s_ack && m_stb[1]) || to));
    check("m0_data", m0_rdata, (owner == 1 && !to) ? s_data : 32'h0);
    check("m1_data", m1_rdata, (owner == 2 && !to) ? s_data : 32'h0);
  endtask

  task automatic model_advance();
    int nxt;
    bit to;
    if (rst) begin
      owner = 0; waitc = 0; pref_m1 = 1'b1; model_valid = 1'b1;
      return;
    end
    if (!model_valid) return;
    to = model_timeout();
    if (owner == 0) begin
      if (m_cyc[0] && m_cyc[1]) nxt = (RR && !pref_m1) ? 1 : 2;
      else if (m_cyc[1])        nxt = 2;
      else if (m_cyc[0])        nxt = 1;
      else                      nxt = 0;
      if (nxt != 0) pref_m1 = (nxt == 1);
    end else begin
      nxt = m_cyc[owner-1] ? owner : 0;
    end
    if (s_ack || to || nxt != owner)      waitc = 0;
    else if (owner != 0 && m_stb[owner-1]) waitc++;
    owner = nxt;
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are sampled
  // 1 unit later, well clear of either clock edge.
  task automatic settle();
    #1;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0;
      m_cti[i] = CTI_CLASSIC; m_bte[i] = '0; m_sel[i] = '0; m_wdat[i] = '0;
    end
    s_ack = 1'b0; s_data = '0;
  endtask

  task automatic drive(input int i, input logic cyc, input logic stb,
                       input logic [29:0] addr, input logic [2:0] cti);
    m_cyc[i] = cyc; m_stb[i] = stb; m_addr[i] = addr; m_cti[i] = cti;
    m_sel[i] = 4'hf; m_we[i] = 1'b0; m_wdat[i] = 32'h0000_0000 | {2'b00, addr};
  endtask

  initial begin
    logic [1:0] exp_gnt;
    bit         noack;
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    settle();
    check("reset_gnt", gnt_o, 2'b00);
    check("reset_cyc", s_cyc_o, 1'b0);
    cycle();

    // Classic read from m0 with the slave answering on the third granted cycle.
    drive(0, 1'b1, 1'b1, 30'h100, CTI_CLASSIC);
    settle();
    check("t1_no_cyc_yet", s_cyc_o, 1'b0);
    cycle();
    check("t1_cyc_granted", s_cyc_o, 1'b1);
    cycle();
    cycle();
    s_ack = 1'b1; s_data = 32'hDEAD_BEEF;
    settle();
    check("t1_ack",  m0_ack, 1'b1);
    check("t1_data", m0_rdata, 32'hDEAD_BEEF);
    check("t1_m1_ack", m1_ack, 1'b0);
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // Four simultaneous requests: tie-break policy.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b1, 30'h200 + k, CTI_CLASSIC);
      drive(1, 1'b1, 1'b1, 30'h300 + k, CTI_CLASSIC);
      cycle();
      exp_gnt = (RR && (k % 2 == 1)) ? 2'b01 : 2'b10;
      s_ack = 1'b1; s_data = 32'h1000 + k;
      settle();
      check("t2_tie_gnt", gnt_o, exp_gnt);
      cycle();
      idle_inputs();
      cycle();
      cycle();
    end

    // m1 four-beat burst; m0 requests at beat 2 and must wait.
    drive(1, 1'b1, 1'b1, 30'h400, CTI_INCR);
    cycle();
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, 1'b1, 30'h400 + b, (b == 3) ? CTI_END : CTI_INCR);
      if (b >= 1) drive(0, 1'b1, 1'b1, 30'h500, CTI_CLASSIC);
      s_ack = 1'b1; s_data = 32'hB000 + b;
      settle();
      check("t3_burst_gnt", gnt_o, 2'b10);
      cycle();
    end
    drive(1, 1'b0, 1'b0, 30'h0, CTI_CLASSIC);
    s_ack = 1'b0;
    cycle();
    check("t3_gap_gnt", gnt_o, 2'b00);
    cycle();
    check("t3_m0_gnt", gnt_o, 2'b01);
    s_ack = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // Slave never acks: timeout on wait cycles 8 and 16.
    drive(0, 1'b1, 1'b1, 30'h600, CTI_CLASSIC);
    s_data = 32'h1234_5678;
    cycle();
    for (int w = 1; w <= 2 * TO; w++) begin
      settle();
      check("t4_timeout", timeout_o, (w % TO) == 0);
      if (w == TO) begin
        check("t4_forced_ack", m0_ack, 1'b1);
        check("t4_zero_data", m0_rdata, 32'h0);
        check("t4_stb_masked", s_stb_o, 1'b0);
      end
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();

    // Real ack on the would-be timeout cycle wins.
    drive(0, 1'b1, 1'b1, 30'h700, CTI_CLASSIC);
    cycle();
    for (int w = 1; w < TO; w++) cycle();
    s_ack = 1'b1; s_data = 32'hCAFE_F00D;
    settle();
    check("t5_no_timeout", timeout_o, 1'b0);
    check("t5_ack", m0_ack, 1'b1);
    check("t5_data", m0_rdata, 32'hCAFE_F00D);
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // Reset in the middle of an m0 burst with the slave still acking.
    drive(0, 1'b1, 1'b1, 30'h800, CTI_INCR);
    cycle();
    s_ack = 1'b1; s_data = 32'h0BAD_0BAD;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    settle();
    check("t6_cyc_dropped", s_cyc_o, 1'b0);
    check("t6_gnt_idle", gnt_o, 2'b00);
    check("t6_no_ack", m0_ack, 1'b0);
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // Random traffic with occasional resets and ack-starved stretches.
    noack = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom % 96) == 0;
      for (int i = 0; i < 2; i++) begin
        if ($urandom % 8 == 0) m_cyc[i] = !m_cyc[i];
        m_stb[i]  = m_cyc[i] && ($urandom % 4 != 0);
        m_we[i]   = 1'($urandom);
        m_addr[i] = 30'($urandom);
        m_cti[i]  = 3'($urandom);
        m_bte[i]  = 2'($urandom);
        m_sel[i]  = 4'($urandom);
        m_wdat[i] = $urandom;
      end
      if ($urandom % 32 == 0) noack = !noack;
      s_ack  = !noack && ($urandom % 3 == 0);
      s_data = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
